// File: rtl/vga_rx.sv
// ----------------------------------------------------------------------------
// vga_rx : receiving end of the 640x480@60 VGA link.
//
// Samples HS/VS and 4-bit RGB on the pixel clock. Recovers active-area pixel
// coordinates and measures line and frame lengths. Declares lock after
// LOCK_FRAMES consecutive good frames.
//
// The pin-to-output latency is a fixed 2 cycles. Consider a pixel that is
// present on the pins in the first HS-low cycle. Two cycles later it appears
// on oR/oG/oB, with the line counter at 0.
//
// Ports
//   clk               pixel clock
//   reset             synchronous, active-high
//   VGA_HS, VGA_VS    syncs, active low
//   iR, iG, iB        pixel colour in
//   oX, oY            active-area column / row; hold outside the active area
//   display           pixel inside active area and link locked
//   oR, oG, oB        captured colour, 0 when display=0
//   locked            timing matches the parameters
//   frame_start       pulse per VS fall (not the first after reset)
//   line_err          pulse when a measured line length != H_TOTAL
//   h_len, v_len      last measured line length (clocks) / frame length (lines)
//   o_dbg_state       lock FSM state (0 SEARCH, 1 TRACK, 2 LOCKED)
// ----------------------------------------------------------------------------
module vga_rx #(
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int H_ACTIVE    = 640,
   parameter int H_TOTAL     = 800,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int V_ACTIVE    = 480,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       VGA_HS,
   input  logic       VGA_VS,
   input  logic [3:0] iR,
   input  logic [3:0] iG,
   input  logic [3:0] iB,
   output logic [9:0] oX,
   output logic [9:0] oY,
   output logic       display,
   output logic [3:0] oR,
   output logic [3:0] oG,
   output logic [3:0] oB,
   output logic       locked,
   output logic       frame_start,
   output logic       line_err,
   output logic [9:0] h_len,
   output logic [9:0] v_len,
   output logic [1:0] o_dbg_state
);

   localparam logic [9:0] C_H_START = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] C_H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [9:0] C_V_START = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] C_V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [9:0] C_H_TOTAL = 10'(H_TOTAL);
   localparam logic [9:0] C_V_TOTAL = 10'(V_TOTAL);
   localparam logic [3:0] C_LOCK    = 4'(LOCK_FRAMES);
   localparam logic [9:0] C_MAX     = 10'h3FF;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Two-stage input pipeline. Syncs idle high in reset so no false edge.
   logic        r_hs1, r_vs1, r_hs2, r_vs2;
   logic [11:0] r_rgb1, r_rgb2;

   logic [9:0]  r_h_cnt, r_v_cnt;
   logic        r_h_seen, r_v_seen;
   logic [9:0]  r_h_len, r_v_len;
   logic        r_line_err, r_frame_start, r_vs_evt;

   state_t      r_state;
   logic [3:0]  r_good_cnt;
   logic        r_frame_ok;
   logic        r_locked;
   logic [9:0]  r_x_last, r_y_last;

   logic        w_hs_fall, w_vs_fall, w_h_sat, w_active, w_frame_good;
   logic [9:0]  w_h_len_next, w_v_len_next, w_x, w_y;

   assign w_hs_fall = r_hs2 & ~r_hs1;
   assign w_vs_fall = r_vs2 & ~r_vs1;
   assign w_h_sat   = (r_h_cnt == C_MAX);

   // A saturated counter reports the ceiling instead of wrapping to 0.
   assign w_h_len_next = w_h_sat ? C_MAX : r_h_cnt + 10'd1;
   assign w_v_len_next = (r_v_cnt == C_MAX) ? C_MAX : r_v_cnt + 10'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hs1  <= 1'b1;
         r_vs1  <= 1'b1;
         r_hs2  <= 1'b1;
         r_vs2  <= 1'b1;
         r_rgb1 <= '0;
         r_rgb2 <= '0;
      end else begin
         r_hs1  <= VGA_HS;
         r_vs1  <= VGA_VS;
         r_rgb1 <= {iR, iG, iB};
         r_hs2  <= r_hs1;
         r_vs2  <= r_vs1;
         r_rgb2 <= r_rgb1;
      end
   end

   // Position counters. A VS clear beats a coincident HS increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         if (w_hs_fall)     r_h_cnt <= '0;
         else if (!w_h_sat) r_h_cnt <= r_h_cnt + 10'd1;

         if (w_vs_fall)                         r_v_cnt <= '0;
         else if (w_hs_fall && r_v_cnt != C_MAX) r_v_cnt <= r_v_cnt + 10'd1;
      end
   end

   // Length measurement. The first edge of each kind only arms the seen flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_seen      <= 1'b0;
         r_v_seen      <= 1'b0;
         r_h_len       <= '0;
         r_v_len       <= '0;
         r_line_err    <= 1'b0;
         r_frame_start <= 1'b0;
         r_vs_evt      <= 1'b0;
      end else begin
         r_line_err    <= 1'b0;
         r_frame_start <= 1'b0;
         // Delayed VS event lines up with the freshly written v_len.
         r_vs_evt      <= w_vs_fall;
         if (w_hs_fall) begin
            r_h_seen <= 1'b1;
            if (r_h_seen) begin
               r_h_len    <= w_h_len_next;
               r_line_err <= (w_h_len_next != C_H_TOTAL);
            end
         end
         if (w_vs_fall) begin
            r_v_seen <= 1'b1;
            if (r_v_seen) begin
               r_v_len       <= w_v_len_next;
               r_frame_start <= 1'b1;
            end
         end
      end
   end

   // Lock FSM. It acts on the registered line_err/vs events, so locked moves
   // the cycle after the event is visible on the outputs.
   assign w_frame_good = r_frame_ok && !r_line_err && !w_h_sat && (r_v_len == C_V_TOTAL);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_SEARCH;
         r_good_cnt <= '0;
         r_frame_ok <= 1'b0;
         r_locked   <= 1'b0;
      end else begin
         case (r_state)
            ST_SEARCH: begin
               if (r_vs_evt) begin
                  r_state    <= ST_TRACK;
                  r_good_cnt <= '0;
                  r_frame_ok <= 1'b1;
               end
            end
            ST_TRACK: begin
               if (r_vs_evt) begin
                  r_frame_ok <= 1'b1;
                  if (w_frame_good) begin
                     r_good_cnt <= r_good_cnt + 4'd1;
                     if (r_good_cnt + 4'd1 == C_LOCK) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                     end
                  end else begin
                     r_good_cnt <= '0;
                  end
               end else if (r_line_err || w_h_sat) begin
                  r_frame_ok <= 1'b0;
               end
            end
            ST_LOCKED: begin
               if (r_line_err || w_h_sat || (r_vs_evt && r_v_len != C_V_TOTAL)) begin
                  r_state    <= ST_SEARCH;
                  r_locked   <= 1'b0;
                  r_good_cnt <= '0;
               end
            end
            default: begin
               r_state  <= ST_SEARCH;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   // Active-area decode straight from the counters and stage-2 colour.
   assign w_active = (r_h_cnt >= C_H_START) && (r_h_cnt < C_H_END) &&
                     (r_v_cnt >= C_V_START) && (r_v_cnt < C_V_END);
   assign w_x = r_h_cnt - C_H_START;
   assign w_y = r_v_cnt - C_V_START;

   // Coordinates of the last active pixel, shown while outside the area.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x_last <= '0;
         r_y_last <= '0;
      end else if (w_active) begin
         r_x_last <= w_x;
         r_y_last <= w_y;
      end
   end

   assign oX          = w_active ? w_x : r_x_last;
   assign oY          = w_active ? w_y : r_y_last;
   assign display     = w_active & r_locked;
   assign oR          = display ? r_rgb2[11:8] : 4'd0;
   assign oG          = display ? r_rgb2[7:4]  : 4'd0;
   assign oB          = display ? r_rgb2[3:0]  : 4'd0;
   assign locked      = r_locked;
   assign frame_start = r_frame_start;
   assign line_err    = r_line_err;
   assign h_len       = r_h_len;
   assign v_len       = r_v_len;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_rx.sv
// ----------------------------------------------------------------------------
// tb_vga_rx : directed bench for vga_rx on a shrunken raster so full frames
// stay short. Timing used here:
//   H: sync 16, back 8, active 64, total 100 -> active h 24..87
//   V: sync 2,  back 3, active 10, total 20  -> active v 5..14
// Pixel pattern: R = h[3:0] (4'hA at h=24,v=5), G = line[3:0], B = ~h[3:0].
// Inputs change 1 time unit after each rising edge. Outputs are read at that
// same point, so after driving pixels 0..n the outputs show pixel n-1.
// ----------------------------------------------------------------------------
module tb_vga_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       VGA_HS, VGA_VS;
   logic [3:0] iR, iG, iB;
   logic [9:0] oX, oY;
   logic       display;
   logic [3:0] oR, oG, oB;
   logic       locked, frame_start, line_err;
   logic [9:0] h_len, v_len;
   logic [1:0] o_dbg_state;

   int n_checks = 0;
   int n_err    = 0;
   int n_le     = 0;
   int n_fs     = 0;

   vga_rx #(
      .H_SYNC(16), .H_BACK(8), .H_ACTIVE(64), .H_TOTAL(100),
      .V_SYNC(2),  .V_BACK(3), .V_ACTIVE(10), .V_TOTAL(20),
      .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .reset(reset), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .iR(iR), .iG(iG), .iB(iB), .oX(oX), .oY(oY), .display(display),
      .oR(oR), .oG(oG), .oB(oB), .locked(locked), .frame_start(frame_start),
      .line_err(line_err), .h_len(h_len), .v_len(v_len), .o_dbg_state(o_dbg_state)
   );

   // Clock / pulse monitors
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (line_err === 1'b1)    n_le++;
      if (frame_start === 1'b1) n_fs++;
   end

   // Driver tasks
   task automatic tick(input logic hs, input logic vs, input logic [3:0] r,
                       input logic [3:0] g, input logic [3:0] b);
      VGA_HS = hs;
      VGA_VS = vs;
      iR     = r;
      iG     = g;
      iB     = b;
      @(posedge clk);
      #1;
   endtask

   // Drive pixels [from, to) of raster line 'line'.
   task automatic line_part(input int line, input int from, input int to);
      for (int c = from; c < to; c++) begin
         logic [3:0] r;
         r = (c == 24 && line == 5) ? 4'hA : 4'(c);
         tick((c < 16) ? 1'b0 : 1'b1, (line < 2) ? 1'b0 : 1'b1, r, 4'(line), ~4'(c));
      end
   endtask

   task automatic lines(input int first, input int last);
      for (int l = first; l <= last; l++) line_part(l, 0, 100);
   endtask

   task automatic frame();
      lines(0, 19);
   endtask

   // Comparison
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_oX"}, oX, 0);
      chk({tag, "_oY"}, oY, 0);
      chk({tag, "_display"}, display, 0);
      chk({tag, "_rgb"}, {oR, oG, oB}, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_line_err"}, line_err, 0);
      chk({tag, "_h_len"}, h_len, 0);
      chk({tag, "_v_len"}, v_len, 0);
      chk({tag, "_state"}, o_dbg_state, 0);
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      repeat (3) tick(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
      chk_all_zero("reset");
      reset = 1'b0;

      // 1: three nominal frames -> lock one cycle after the fall is visible
      frame();
      frame();
      chk("t1_track_after_f2", o_dbg_state, 1);
      line_part(0, 0, 2);
      chk("t1_locked_pre", locked, 0);
      chk("t1_frame_start", frame_start, 1);
      chk("t1_v_len", v_len, 20);
      chk("t1_h_len", h_len, 100);
      line_part(0, 2, 3);
      chk("t1_locked", locked, 1);
      chk("t1_state_locked", o_dbg_state, 2);
      chk("t1_no_line_err", n_le, 0);
      chk("t1_fs_count", n_fs, 2);

      // 2: active-area boundaries and 2-cycle latency
      line_part(0, 3, 100);
      lines(1, 4);
      line_part(5, 0, 25);
      chk("t2_pre_display", display, 0);
      chk("t2_pre_oX_hold", oX, 63);
      line_part(5, 25, 26);
      chk("t2_first_oX", oX, 0);
      chk("t2_first_oY", oY, 0);
      chk("t2_first_display", display, 1);
      chk("t2_first_rgb", {oR, oG, oB}, 12'hA57);
      line_part(5, 26, 89);
      chk("t2_last_oX", oX, 63);
      chk("t2_last_display", display, 1);
      chk("t2_last_rgb", {oR, oG, oB}, 12'h758);
      line_part(5, 89, 90);
      chk("t2_after_display", display, 0);
      chk("t2_after_oX_hold", oX, 63);
      chk("t2_after_rgb", {oR, oG, oB}, 0);
      line_part(5, 90, 100);
      lines(6, 19);

      // 3: one short line drops lock, relock after three more VS falls
      lines(0, 9);
      line_part(10, 0, 99);
      line_part(11, 0, 2);
      chk("t3_line_err", line_err, 1);
      chk("t3_h_len", h_len, 99);
      chk("t3_locked_still", locked, 1);
      line_part(11, 2, 3);
      chk("t3_unlocked", locked, 0);
      chk("t3_line_err_pulse", line_err, 0);
      chk("t3_state_search", o_dbg_state, 0);
      line_part(11, 3, 100);
      lines(12, 19);
      frame();
      chk("t3_track", o_dbg_state, 1);
      frame();
      chk("t3_not_yet", locked, 0);
      line_part(0, 0, 3);
      chk("t3_relocked", locked, 1);
      chk("t3_le_count", n_le, 1);

      // 4: 19-line frame drops lock at the next VS fall, count restarts
      line_part(0, 3, 100);
      lines(1, 18);
      line_part(0, 0, 2);
      chk("t4_v_len", v_len, 19);
      chk("t4_locked_still", locked, 1);
      line_part(0, 2, 3);
      chk("t4_unlocked", locked, 0);
      chk("t4_state_search", o_dbg_state, 0);
      line_part(0, 3, 100);
      lines(1, 19);
      chk("t4_still_search", o_dbg_state, 0);
      frame();
      chk("t4_track", o_dbg_state, 1);
      frame();
      chk("t4_not_yet", locked, 0);
      line_part(0, 0, 3);
      chk("t4_relocked", locked, 1);

      // 5: HS stuck high -> saturation, lock lost, colour blanked
      line_part(0, 3, 100);
      lines(1, 6);
      line_part(7, 0, 41);
      chk("t5_display_before", display, 1);
      chk("t5_oX_before", oX, 15);
      chk("t5_oY_before", oY, 2);
      repeat (1100) tick(1'b1, 1'b1, 4'hC, 4'hC, 4'hC);
      chk("t5_unlocked", locked, 0);
      chk("t5_display", display, 0);
      chk("t5_rgb", {oR, oG, oB}, 0);
      chk("t5_oX_hold", oX, 63);
      chk("t5_oY_hold", oY, 2);
      chk("t5_state", o_dbg_state, 0);
      line_part(0, 0, 2);
      chk("t5_resume_line_err", line_err, 1);
      chk("t5_resume_h_len", h_len, 1023);

      // 6: reset mid-line while locked
      line_part(0, 2, 100);
      lines(1, 19);
      frame();
      line_part(0, 0, 3);
      chk("t6_relocked", locked, 1);
      line_part(0, 3, 100);
      lines(1, 4);
      line_part(5, 0, 41);
      chk("t6_display_before", display, 1);
      reset = 1'b1;
      line_part(5, 41, 42);
      chk_all_zero("t6_reset");
      reset = 1'b0;
      line_part(5, 42, 100);
      line_part(6, 0, 2);
      chk("t6_first_fall_no_err", line_err, 0);
      chk("t6_first_fall_h_len", h_len, 0);
      line_part(6, 2, 100);
      line_part(7, 0, 2);
      chk("t6_second_fall_err", line_err, 0);
      chk("t6_second_fall_h_len", h_len, 100);
      chk("t6_locked", locked, 0);
      chk("t6_le_count", n_le, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
